// File: rtl/sram_loader_pkg.sv
// rtl/sram_loader_pkg.sv - shared types and constants for the SRAM frame loader
//
// Purpose: state encodings for the byte-packing FSM and the SRAM write port,
// plus the default SRAM geometry and frame size.
// Ports: none (package).
package sram_loader_pkg;

  localparam int SRAM_ADDR_W         = 20;
  localparam int FRAME_640x480_WORDS = 307200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } loader_state_t;

  // Phases of a single SRAM word write, tracked inside sram_write_port.
  typedef enum logic [1:0] {
    WP_IDLE,
    WP_SETUP,
    WP_WRITE,
    WP_HOLD
  } write_phase_t;

endpackage

// File: rtl/sram_write_port.sv
// rtl/sram_write_port.sv - single-word SRAM write sequencer (setup, WE pulse, hold)
//
// Purpose: on i_start, latches address/data and runs one SETUP cycle,
// WE_CYCLES cycles with we_n low, and one HOLD cycle, then releases the bus.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_start             begin a word write (accepted only when idle)
//   i_addr, i_data      word address and data, sampled with i_start
//   o_ack               high during the last WE-low cycle; the packer moves to HOLD on it
//   o_sram_*            registered SRAM address, data, DQ enable and strobes
module sram_write_port
  import sram_loader_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int WE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_data,
  output logic              o_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq,
  output logic              o_sram_dq_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WE_CYCLES - 1);

  write_phase_t     phase, phase_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase <= WP_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    case (phase)
      WP_IDLE:  if (i_start) phase_next = WP_SETUP;
      WP_SETUP: begin
        phase_next = WP_WRITE;
        cnt_next   = '0;
      end
      WP_WRITE: begin
        if (cnt == LAST_CNT) phase_next = WP_HOLD;
        else                 cnt_next   = cnt + 1'b1;
      end
      WP_HOLD:  phase_next = WP_IDLE;
      default:  phase_next = WP_IDLE;
    endcase
  end

  // Strobes are registered from the next phase so every pin changes
  // exactly on the edge that enters the corresponding phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ack        <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_sram_dq_oe <= 1'b0;
      o_sram_ce_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
    end else begin
      o_ack        <= (phase_next == WP_WRITE) && (cnt_next == LAST_CNT);
      o_sram_dq_oe <= (phase_next != WP_IDLE);
      o_sram_ce_n  <= (phase_next == WP_IDLE);
      o_sram_lb_n  <= (phase_next == WP_IDLE);
      o_sram_ub_n  <= (phase_next == WP_IDLE);
      o_sram_we_n  <= (phase_next != WP_WRITE);
      if (phase == WP_IDLE && i_start) begin
        o_sram_addr <= i_addr;
        o_sram_dq   <= i_data;
      end
    end
  end

endmodule

// File: rtl/sram_frame_loader.sv
// rtl/sram_frame_loader.sv - packs upstream bytes into 16-bit words and stores a frame in SRAM
//
// Purpose: after i_start, accepts byte pairs (low byte first), writes each
// word to consecutive SRAM addresses from the latched base, and pulses
// o_done after FRAME_WORDS words.
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_start, i_base_addr           begin a frame at the given word address
//   i_byte_valid, i_byte, o_byte_ready   upstream byte handshake
//   o_sram_addr, o_sram_dq, o_sram_dq_oe SRAM address, write data, DQ drive enable
//   o_sram_ce_n/oe_n/we_n/lb_n/ub_n      SRAM strobes (oe_n is always high)
//   o_busy, o_done, o_word_count         progress reporting
module sram_frame_loader
  import sram_loader_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int FRAME_WORDS = FRAME_640x480_WORDS,
  parameter int WE_CYCLES   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_dq,
  output logic              o_sram_dq_oe,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_word_count
);

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_inc;
  logic [7:0]        data_lo;
  logic              handshake;
  logic              last_word;
  logic              wr_start;
  logic              wr_ack;

  assign handshake    = i_byte_valid & o_byte_ready;
  assign count_inc    = count_q + 1'b1;
  assign last_word    = (count_inc == ADDR_W'(FRAME_WORDS));
  // The write port must enter SETUP on the same edge that takes the high byte.
  assign wr_start     = (state == ST_HI) && handshake;
  assign o_sram_oe_n  = 1'b1;
  assign o_word_count = count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_LO;
      ST_LO:    if (handshake) state_next = ST_HI;
      ST_HI:    if (handshake) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_WRITE;
      ST_WRITE: if (wr_ack) state_next = ST_HOLD;
      ST_HOLD:  state_next = last_word ? ST_DONE : ST_LO;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      data_lo      <= '0;
    end else begin
      o_byte_ready <= (state_next inside {ST_LO, ST_HI});
      o_busy       <= (state_next inside {ST_LO, ST_HI, ST_SETUP, ST_WRITE, ST_HOLD});
      o_done       <= (state_next == ST_DONE);
      if (state == ST_IDLE && i_start) begin
        addr_q  <= i_base_addr;
        count_q <= '0;
      end
      if (state == ST_LO && handshake) data_lo <= i_byte;
      // Address wraps naturally at 2^ADDR_W.
      if (state == ST_HOLD) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_inc;
      end
    end
  end

  sram_write_port #(
    .ADDR_W    (ADDR_W),
    .WE_CYCLES (WE_CYCLES)
  ) u_write_port (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (wr_start),
    .i_addr       (addr_q),
    .i_data       ({i_byte, data_lo}),
    .o_ack        (wr_ack),
    .o_sram_addr  (o_sram_addr),
    .o_sram_dq    (o_sram_dq),
    .o_sram_dq_oe (o_sram_dq_oe),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_lb_n  (o_sram_lb_n),
    .o_sram_ub_n  (o_sram_ub_n)
  );

endmodule

// File: tb/tb_sram_frame_loader.sv
// tb/tb_sram_frame_loader.sv - self-checking bench for sram_frame_loader
module tb_sram_frame_loader;

  localparam int AW = 20;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic            rst_n;
  logic            start_s [2];
  logic [AW-1:0]   base_s  [2];
  logic            valid_s [2];
  logic [7:0]      byte_s  [2];
  logic            rdy_s   [2];
  logic [AW-1:0]   addr_s  [2];
  logic [15:0]     dq_s    [2];
  logic            oe_s    [2];
  logic            ce_s    [2];
  logic            oen_s   [2];
  logic            we_s    [2];
  logic            lb_s    [2];
  logic            ub_s    [2];
  logic            busy_s  [2];
  logic            done_s  [2];
  logic [AW-1:0]   cnt_s   [2];

  sram_frame_loader #(.ADDR_W(AW), .FRAME_WORDS(2), .WE_CYCLES(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[0]), .i_base_addr(base_s[0]),
    .i_byte_valid(valid_s[0]), .i_byte(byte_s[0]), .o_byte_ready(rdy_s[0]),
    .o_sram_addr(addr_s[0]), .o_sram_dq(dq_s[0]), .o_sram_dq_oe(oe_s[0]),
    .o_sram_ce_n(ce_s[0]), .o_sram_oe_n(oen_s[0]), .o_sram_we_n(we_s[0]),
    .o_sram_lb_n(lb_s[0]), .o_sram_ub_n(ub_s[0]), .o_busy(busy_s[0]),
    .o_done(done_s[0]), .o_word_count(cnt_s[0])
  );

  sram_frame_loader #(.ADDR_W(AW), .FRAME_WORDS(2), .WE_CYCLES(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s[1]), .i_base_addr(base_s[1]),
    .i_byte_valid(valid_s[1]), .i_byte(byte_s[1]), .o_byte_ready(rdy_s[1]),
    .o_sram_addr(addr_s[1]), .o_sram_dq(dq_s[1]), .o_sram_dq_oe(oe_s[1]),
    .o_sram_ce_n(ce_s[1]), .o_sram_oe_n(oen_s[1]), .o_sram_we_n(we_s[1]),
    .o_sram_lb_n(lb_s[1]), .o_sram_ub_n(ub_s[1]), .o_busy(busy_s[1]),
    .o_done(done_s[1]), .o_word_count(cnt_s[1])
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt [2];
  int we_len   [2];

  logic [35:0] q0 [$];
  logic [35:0] q1 [$];

  typedef struct {
    int          dut;
    logic [19:0] base;
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [19:0] a0, a1;
    logic [15:0] d0, d1;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask

  task automatic push(input int d, input logic [19:0] a, input logic [15:0] v);
    if (d == 0) q0.push_back({a, v});
    else        q1.push_back({a, v});
  endtask

  // Watches one DUT's SRAM bus: captures address/data at SETUP, checks they
  // stay stable with ready low until the bus is released, measures the WE
  // pulse, and compares the word with the scoreboard.
  task automatic monitor(input int d);
    logic        active = 1'b0;
    logic        ok = 1'b1;
    logic        prev_done = 1'b0;
    int          wlen = 0;
    logic [19:0] a = '0;
    logic [15:0] v = '0;
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (done_s[d] && !prev_done) done_cnt[d]++;
      prev_done = done_s[d];
      if (!rst_n) begin
        active = 1'b0;
      end else if (oe_s[d]) begin
        if (!active) begin
          active = 1'b1;
          a = addr_s[d];
          v = dq_s[d];
          ok = 1'b1;
          wlen = 0;
        end
        if (addr_s[d] !== a || dq_s[d] !== v || rdy_s[d] !== 1'b0 || ce_s[d] !== 1'b0 ||
            lb_s[d] !== 1'b0 || ub_s[d] !== 1'b0 || oen_s[d] !== 1'b1)
          ok = 1'b0;
        if (we_s[d] === 1'b0) wlen++;
      end else if (active) begin
        active = 1'b0;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          fail_now($sformatf("dut%0d_unexpected_write_%0h_%0h", d, a, v));
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d_write_addr_data", d), {a, v}, e);
        end
        chk($sformatf("dut%0d_we_low_cycles", d), 64'(wlen), 64'(we_len[d]));
        chk($sformatf("dut%0d_bus_stable", d), ok, 1);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic do_start(input int d, input logic [19:0] b);
    start_s[d] = 1'b1;
    base_s[d]  = b;
    @(negedge clk);
    start_s[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    valid_s[d] = 1'b1;
    byte_s[d]  = b;
    while (rdy_s[d] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now($sformatf("dut%0d_byte_ready_wait", d));
    @(negedge clk);
    valid_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (done_s[d] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now($sformatf("dut%0d_done_wait", d));
    @(negedge clk);
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (rdy_s[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now($sformatf("dut%0d_ready_wait", d));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int dc;
    int n;

    vecs[0] = '{0, 20'h00010, 8'h34, 8'h12, 8'h78, 8'h56, 0, 20'h00010, 20'h00011, 16'h1234, 16'h5678};
    vecs[1] = '{0, 20'hFFFFF, 8'hAA, 8'h55, 8'h01, 8'h80, 0, 20'hFFFFF, 20'h00000, 16'h55AA, 16'h8001};
    vecs[2] = '{1, 20'h12345, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 0, 20'h12345, 20'h12346, 16'hBEEF, 16'hDEAD};
    vecs[3] = '{0, 20'h00020, 8'h00, 8'hFF, 8'hFF, 8'h00, 5, 20'h00020, 20'h00021, 16'hFF00, 16'h00FF};

    we_len[0] = 1;
    we_len[1] = 3;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      base_s[i]  = '0;
      valid_s[i] = 1'b0;
      byte_s[i]  = '0;
    end
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_byte_ready", i), rdy_s[i], 0);
      chk($sformatf("rst%0d_dq_oe", i), oe_s[i], 0);
      chk($sformatf("rst%0d_dq", i), dq_s[i], 0);
      chk($sformatf("rst%0d_addr", i), addr_s[i], 0);
      chk($sformatf("rst%0d_ce_n", i), ce_s[i], 1);
      chk($sformatf("rst%0d_oe_n", i), oen_s[i], 1);
      chk($sformatf("rst%0d_we_n", i), we_s[i], 1);
      chk($sformatf("rst%0d_lb_ub_n", i), {lb_s[i], ub_s[i]}, 2'b11);
      chk($sformatf("rst%0d_busy", i), busy_s[i], 0);
      chk($sformatf("rst%0d_done", i), done_s[i], 0);
      chk($sformatf("rst%0d_count", i), cnt_s[i], 0);
    end

    rst_n = 1'b1;
    @(negedge clk);

    // Frames 0 and 1 run back to back: each start lands the cycle after done.
    for (int i = 0; i < 4; i++) begin
      d  = vecs[i].dut;
      dc = done_cnt[d];
      push(d, vecs[i].a0, vecs[i].d0);
      push(d, vecs[i].a1, vecs[i].d1);
      do_start(d, vecs[i].base);
      chk($sformatf("v%0d_start_count", i), cnt_s[d], 0);
      chk($sformatf("v%0d_start_busy", i), busy_s[d], 1);
      send_byte(d, vecs[i].b0, vecs[i].gap);
      send_byte(d, vecs[i].b1, vecs[i].gap);
      send_byte(d, vecs[i].b2, vecs[i].gap);
      send_byte(d, vecs[i].b3, vecs[i].gap);
      wait_done(d);
      chk($sformatf("v%0d_word_count", i), cnt_s[d], 2);
      chk($sformatf("v%0d_busy_after", i), busy_s[d], 0);
      chk($sformatf("v%0d_done_one_cycle", i), done_s[d], 0);
      chk($sformatf("v%0d_done_pulses", i), 64'(done_cnt[d] - dc), 1);
      chk($sformatf("v%0d_queue_empty", i), 64'((d == 0) ? q0.size() : q1.size()), 0);
    end

    // A start pulsed while waiting for the second word must not re-latch base or clear count.
    repeat (3) @(negedge clk);
    dc = done_cnt[0];
    push(0, 20'h00100, 16'h2211);
    push(0, 20'h00101, 16'h4433);
    do_start(0, 20'h00100);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    wait_ready(0);
    do_start(0, 20'h00ABC);
    chk("ign_start_count", cnt_s[0], 1);
    chk("ign_start_busy", busy_s[0], 1);
    send_byte(0, 8'h33, 2);
    send_byte(0, 8'h44, 0);
    wait_done(0);
    chk("ign_word_count", cnt_s[0], 2);
    chk("ign_done_pulses", 64'(done_cnt[0] - dc), 1);
    chk("ign_queue_empty", 64'(q0.size()), 0);

    // Reset while we_n is low on the 3-cycle write port.
    push(1, 20'h00300, 16'h6655);
    do_start(1, 20'h00300);
    send_byte(1, 8'h55, 0);
    send_byte(1, 8'h66, 0);
    n = 0;
    while (we_s[1] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("rstw_we_low_wait");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw_we_n", we_s[1], 1);
    chk("rstw_dq_oe", oe_s[1], 0);
    chk("rstw_ce_n", ce_s[1], 1);
    chk("rstw_busy", busy_s[1], 0);
    chk("rstw_byte_ready", rdy_s[1], 0);
    chk("rstw_count", cnt_s[1], 0);
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstw_idle_busy", busy_s[1], 0);
    chk("rstw_idle_we_n", we_s[1], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_frame_loader.md
Name: sram_frame_loader

Overview:
- Upstream stage of the SRAM/VGA frame path: takes the byte stream delivered by the UART receiver and packs byte pairs into 16-bit pixel words.
- Writes each word into the off-chip 1M x 16 SRAM at consecutive addresses from a programmable base address, so the VGA reader can scan the frame out.
- Reports progress for the seven-segment debug display and pulses done when a full frame is stored.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- FRAME_WORDS, 307200, words per frame (640x480 at 16 bpp); must be at least 1.
- WE_CYCLES, 1, cycles `o_sram_we_n` is held low per write; must be at least 1.

Ports:
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins loading a frame.
- i_base_addr  in  ADDR_W  first SRAM word address; sampled on an accepted `i_start`.
- i_byte_valid  in  1  upstream byte valid.
- i_byte  in  8  upstream byte.
- o_byte_ready  out  1  byte accepted on a cycle where valid and ready are both 1.
- o_sram_addr  out  ADDR_W  SRAM address.
- o_sram_dq  out  16  write data.
- o_sram_dq_oe  out  1  tri-state enable for SRAM_DQ (the top level drives DQ only when this is 1).
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM controls.
- o_busy  out  1  high from an accepted `i_start` until done.
- o_done  out  1  one-cycle pulse when the frame is complete.
- o_word_count  out  ADDR_W  words written in the current or last frame.

Behaviour:
- Clocking and reset: one clock, `i_clk`. Reset is synchronous and active-low (`i_rst_n`). All outputs are registered.
- Reset values:
  - state IDLE; `o_byte_ready`=0; `o_sram_dq_oe`=0; `o_sram_dq`=0; `o_sram_addr`=0.
  - `o_sram_ce_n`=`o_sram_we_n`=`o_sram_lb_n`=`o_sram_ub_n`=1.
  - `o_sram_oe_n`=1, held constant 1 at all times (write-only block).
  - `o_busy`=0; `o_done`=0; `o_word_count`=0.
- Reset asserted mid-write: `we_n` returns high and DQ is released at the same edge. No partial word is completed.
- States: IDLE, LO, HI, SETUP, WRITE, HOLD, DONE.
- IDLE:
  - `i_start`=1 → latch `i_base_addr` into the address register, clear `o_word_count`, set `o_busy`, go to LO.
  - `i_start` while not in IDLE is ignored.
- LO: `o_byte_ready`=1; on a handshake, store the byte as data[7:0] and go to HI.
- HI: `o_byte_ready`=1; on a handshake, store the byte as data[15:8] and go to SETUP. Byte order is little-endian: the first byte is the low byte.
- SETUP (1 cycle): drive address and data; `dq_oe`=1; `ce_n`=`lb_n`=`ub_n`=0; `we_n`=1.
- WRITE (WE_CYCLES cycles): `we_n`=0, with address and data stable.
- HOLD (1 cycle):
  - `we_n`=1, data still driven.
  - Increment `o_word_count` and the address.
  - If the new count equals FRAME_WORDS, go to DONE; otherwise go to LO.
- Leaving HOLD: `dq_oe`=0, `ce_n`=`lb_n`=`ub_n`=1.
- DONE (1 cycle): `o_done`=1, `o_busy`=0, go to IDLE.
- Per-word cost: 2+WE_CYCLES cycles of SRAM activity, plus at least 2 handshake cycles.
- `o_byte_ready` is 0 in every state other than LO and HI, so upstream must hold the byte.
- Address arithmetic is modulo 2^ADDR_W: base + count wraps from 0xFFFFF to 0x00000 with no error.
- `o_word_count` holds its final value after DONE until the next accepted start.
- `i_byte_valid` gaps of any length in LO or HI are tolerated; no timeout.
- `o_sram_addr` and `o_sram_dq` hold their last values when idle.

Decomposition:
- Package `sram_loader_pkg`:
  - state enum `loader_state_t` with the 7 states;
  - constant `SRAM_ADDR_W`=20;
  - default frame size `FRAME_640x480_WORDS`=307200.
- One natural sub-module, `sram_write_port`: handles SETUP/WRITE/HOLD timing for a single word, with a start/ack handshake to the packing FSM.

Test Plan:
- Reset mid-WRITE (assert `i_rst_n`=0 while `we_n`=0) → at the next edge `we_n`=1, `dq_oe`=0, `ce_n`=1, `o_busy`=0, state IDLE.
- FRAME_WORDS=2, base 0x00010, bytes 0x34,0x12,0x78,0x56:
  - → writes 0x1234 @0x00010 and 0x5678 @0x00011;
  - → `we_n` low exactly 1 cycle per word;
  - → `o_done` pulses once; `o_word_count`=2.
- Valid gaps: 5 idle cycles between bytes, plus `i_start` pulsed during LO → same data written; the second start is ignored (base not re-latched, count not cleared).
- Wrap: base 0xFFFFF, FRAME_WORDS=2 → addresses 0xFFFFF then 0x00000; done asserted.
- WE_CYCLES=3 → `we_n` low 3 consecutive cycles; address and DQ stable from SETUP through HOLD; `o_byte_ready`=0 throughout.
- Back-to-back frames: second `i_start` the cycle after `o_done` → count resets to 0, new base latched, second frame written correctly.
